interrupt_priority_control: RTL and testbench

//  Sequencer between the 8-bit interrupt request latch and the CPU acknowledge interface of the PIC.
//  - Resolves the highest-priority unmasked request and raises int_out.
//  - Runs the two-pulse INTA sequence: freezes the request latch and clears the granted request bit.
//  - Owns the in-service register (ISR), EOI handling and priority rotation, and emits the vector byte.

---
 rtl/pic_pkg.sv | 19 +
 rtl/pic_priority_resolver.sv | 30 +++
 rtl/interrupt_priority_control.sv | 151 +++++++++++++++
 tb/tb_interrupt_priority_control.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC acknowledge/priority sequencer.
package pic_pkg;

  localparam int NUM_IR  = 8;
  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] SPUR_LEVEL = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2
  } pic_state_e;

  function automatic logic [NUM_IR-1:0] level_onehot(input logic [LEVEL_W-1:0] lvl);
    level_onehot      = '0;
    level_onehot[lvl] = 1'b1;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating priority encoder: the level just above lp has highest priority,
// descending with wrap-around down to lp itself.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0]  vec,
  input  logic [LEVEL_W-1:0] lp,
  output logic               found,
  output logic [LEVEL_W-1:0] level
);

  logic [LEVEL_W-1:0]  start;
  logic [2*NUM_IR-1:0] dbl;
  logic [NUM_IR-1:0]   rot;
  logic [LEVEL_W-1:0]  idx;

  always_comb begin
    start = lp + 3'd1;
    dbl   = {vec, vec};
    // rot[i] holds the level that is i steps below the highest priority
    rot   = dbl[start +: NUM_IR];
    idx   = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (rot[i]) idx = LEVEL_W'(i);
    end
    found = |vec;
    level = start + idx;
  end

endmodule

// File: rtl/interrupt_priority_control.sv
// PIC sequencer: request resolution, two-pulse INTA handshake, ISR/EOI and rotation.
// Define PIC_AUTO_EOI_EN to add the auto_eoi port (ISR bit cleared in the vector cycle).
module interrupt_priority_control
  import pic_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IR-1:0]    interrupt_req_reg,
  input  logic [NUM_IR-1:0]    interrupt_mask,
  input  logic [4:0]           vector_base,
  input  logic                 inta_pulse,
  input  logic                 eoi_valid,
  input  logic                 eoi_specific,
  input  logic [LEVEL_W-1:0]   eoi_level,
  input  logic                 rotate_on_eoi,
`ifdef PIC_AUTO_EOI_EN
  input  logic                 auto_eoi,
`endif
  output logic                 int_out,
  output logic                 freeze,
  output logic [NUM_IR-1:0]    clear_interrupt_req,
  output logic [NUM_IR-1:0]    in_service_reg,
  output logic [7:0]           vector_out,
  output logic                 vector_valid
);

  pic_state_e         state_q, state_d;
  logic [LEVEL_W-1:0] win_q, win_d;
  logic               spur_q, spur_d;
  logic [NUM_IR-1:0]  isr_q, isr_d;
  logic [LEVEL_W-1:0] lp_q, lp_d;
  logic               int_out_q, int_out_d;
  logic [7:0]         vector_out_q, vector_out_d;
  logic               vector_valid_q, vector_valid_d;

  logic [NUM_IR-1:0]  eligible;
  logic               req_found, isr_found;
  logic [LEVEL_W-1:0] req_level, isr_level;
  logic [LEVEL_W-1:0] req_rank, isr_rank;
  logic               ack_set, vector_fire, auto_hit, eoi_hit;
  logic [LEVEL_W-1:0] eoi_target;

  assign eligible = interrupt_req_reg & ~interrupt_mask;

  pic_priority_resolver u_req_res (
    .vec   (eligible),
    .lp    (lp_q),
    .found (req_found),
    .level (req_level)
  );

  pic_priority_resolver u_isr_res (
    .vec   (isr_q),
    .lp    (lp_q),
    .found (isr_found),
    .level (isr_level)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inta_pulse) state_d = ACK1;
      ACK1:    state_d = WAIT2;
      WAIT2:   if (inta_pulse) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM-derived strobes
  always_comb begin
    freeze              = (state_q != IDLE);
    ack_set             = (state_q == ACK1) && !spur_q;
    clear_interrupt_req = ack_set ? level_onehot(win_q) : '0;
    vector_fire         = (state_q == WAIT2) && inta_pulse;
  end

  // Datapath: winner latch, ISR, rotation pointer, int_out and vector
  always_comb begin
    win_d  = win_q;
    spur_d = spur_q;
    if (state_q == IDLE && inta_pulse) begin
      win_d  = req_found ? req_level : SPUR_LEVEL;
      spur_d = !req_found;
    end

`ifdef PIC_AUTO_EOI_EN
    auto_hit = vector_fire && auto_eoi && !spur_q;
`else
    auto_hit = 1'b0;
`endif

    // A non-specific EOI with an empty ISR lands on a clear bit and is a no-op
    eoi_target = eoi_specific ? eoi_level : isr_level;
    eoi_hit    = eoi_valid && isr_q[eoi_target];

    isr_d = isr_q;
    lp_d  = lp_q;
    if (eoi_hit) begin
      isr_d = isr_d & ~level_onehot(eoi_target);
      if (rotate_on_eoi) lp_d = eoi_target;
    end
    if (auto_hit) begin
      isr_d = isr_d & ~level_onehot(win_q);
      if (rotate_on_eoi) lp_d = win_q;
    end
    // The acknowledge set is applied last so it beats a same-cycle EOI
    if (ack_set) isr_d = isr_d | level_onehot(win_q);

    // Ranks relative to the highest-priority slot; smaller is more urgent
    req_rank  = req_level - (lp_q + 3'd1);
    isr_rank  = isr_level - (lp_q + 3'd1);
    int_out_d = req_found && (!isr_found || (req_rank < isr_rank))
                && (state_q != ACK1) && (state_d != ACK1);

    vector_valid_d = vector_fire;
    vector_out_d   = vector_fire ? {vector_base, win_q} : vector_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q          <= '0;
      spur_q         <= 1'b0;
      isr_q          <= '0;
      lp_q           <= 3'd7;
      int_out_q      <= 1'b0;
      vector_out_q   <= '0;
      vector_valid_q <= 1'b0;
    end else begin
      win_q          <= win_d;
      spur_q         <= spur_d;
      isr_q          <= isr_d;
      lp_q           <= lp_d;
      int_out_q      <= int_out_d;
      vector_out_q   <= vector_out_d;
      vector_valid_q <= vector_valid_d;
    end
  end

  assign int_out        = int_out_q;
  assign in_service_reg = isr_q;
  assign vector_out     = vector_out_q;
  assign vector_valid   = vector_valid_q;

endmodule

// File: tb/tb_interrupt_priority_control.sv
// Bench for interrupt_priority_control: directed scenarios plus randomized
// acknowledge/EOI traffic checked against a level-based priority model.
module tb_interrupt_priority_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irr, imr;
  logic [4:0] base;
  logic       inta, eoi_valid, eoi_spec, rot;
  logic [2:0] eoi_lvl;
`ifdef PIC_AUTO_EOI_EN
  logic       auto_eoi;
`endif
  logic       int_out, freeze, vector_valid;
  logic [7:0] clear_req, isr, vector_out;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] isr_m;
  int         lp_m;

  interrupt_priority_control dut (
    .clk                 (clk),
    .reset               (reset),
    .interrupt_req_reg   (irr),
    .interrupt_mask      (imr),
    .vector_base         (base),
    .inta_pulse          (inta),
    .eoi_valid           (eoi_valid),
    .eoi_specific        (eoi_spec),
    .eoi_level           (eoi_lvl),
    .rotate_on_eoi       (rot),
`ifdef PIC_AUTO_EOI_EN
    .auto_eoi            (auto_eoi),
`endif
    .int_out             (int_out),
    .freeze              (freeze),
    .clear_interrupt_req (clear_req),
    .in_service_reg      (isr),
    .vector_out          (vector_out),
    .vector_valid        (vector_valid)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int top_level(input logic [7:0] v);
    for (int k = 1; k <= 8; k++) begin
      int l;
      l = (lp_m + k) % 8;
      if (v[l]) return l;
    end
    return -1;
  endfunction

  function automatic int rank(input int l);
    return (l - lp_m - 1 + 16) % 8;
  endfunction

  function automatic logic exp_int();
    int t, i;
    t = top_level(irr & ~imr);
    i = top_level(isr_m);
    if (t < 0) return 1'b0;
    if (i < 0) return 1'b1;
    return rank(t) < rank(i);
  endfunction

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; irr = '0; imr = '0; base = '0; inta = 1'b0;
    eoi_valid = 1'b0; eoi_spec = 1'b0; eoi_lvl = '0; rot = 1'b0;
`ifdef PIC_AUTO_EOI_EN
    auto_eoi = 1'b0;
`endif
    cyc(); cyc();
    reset = 1'b0;
    isr_m = '0;
    lp_m  = 7;
  endtask

  // Full two-pulse acknowledge with model update and checks
  task automatic run_ack(input int wait_cycles);
    int         t;
    logic [7:0] exp_clr, exp_vec;
    logic [2:0] lv;
    logic       auto_on;
    t       = top_level(irr & ~imr);
    exp_clr = (t < 0) ? 8'h00 : (8'h01 << t);
    lv      = (t < 0) ? 3'd7 : 3'(t);
    exp_vec = {base, lv};
    inta = 1'b1; cyc(); inta = 1'b0;
    vectors++;
    if (clear_req !== exp_clr || freeze !== 1'b1 || int_out !== 1'b0) begin
      miscompares++;
      $display("FAIL ack1: clear=%h freeze=%b int=%b required clear=%h freeze=1 int=0",
               clear_req, freeze, int_out, exp_clr);
    end
    cyc();
    if (t >= 0) begin
      isr_m[t] = 1'b1;
      irr[t]   = 1'b0;
    end
    vectors++;
    if (isr !== isr_m || freeze !== 1'b1 || clear_req !== 8'h00) begin
      miscompares++;
      $display("FAIL wait2: isr=%h freeze=%b clear=%h required isr=%h freeze=1 clear=00",
               isr, freeze, clear_req, isr_m);
    end
    for (int w = 0; w < wait_cycles; w++) begin
      imr = 8'($urandom);
      cyc();
    end
    inta = 1'b1; cyc(); inta = 1'b0;
`ifdef PIC_AUTO_EOI_EN
    auto_on = auto_eoi;
`else
    auto_on = 1'b0;
`endif
    if (auto_on && t >= 0) begin
      isr_m[t] = 1'b0;
      if (rot) lp_m = t;
    end
    vectors++;
    if (vector_valid !== 1'b1 || vector_out !== exp_vec || freeze !== 1'b0 || isr !== isr_m) begin
      miscompares++;
      $display("FAIL vector: valid=%b vec=%h freeze=%b isr=%h required valid=1 vec=%h freeze=0 isr=%h",
               vector_valid, vector_out, freeze, isr, exp_vec, isr_m);
    end
    cyc();
    vectors++;
    if (vector_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL vector_strobe: valid=%b required 0", vector_valid);
    end
  endtask

  task automatic apply_eoi(input logic spec, input logic [2:0] lvl, input logic r);
    int target;
    eoi_valid = 1'b1; eoi_spec = spec; eoi_lvl = lvl; rot = r;
    target = spec ? int'(lvl) : top_level(isr_m);
    if (target >= 0 && isr_m[target]) begin
      isr_m[target] = 1'b0;
      if (r) lp_m = target;
    end
    cyc();
    eoi_valid = 1'b0; rot = 1'b0;
    vectors++;
    if (isr !== isr_m) begin
      miscompares++;
      $display("FAIL eoi: isr=%h required %h", isr, isr_m);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    vectors++;
    if ({int_out, freeze, clear_req, isr, vector_out, vector_valid} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset: int=%b freeze=%b clr=%h isr=%h vec=%h vv=%b required all 0",
               int_out, freeze, clear_req, isr, vector_out, vector_valid);
    end
  endtask

  task automatic test_basic();
    do_reset();
    irr = 8'h24; imr = 8'h00; base = 5'h08;
    cyc();
    vectors++;
    if (int_out !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_int: int=%b required 1", int_out);
    end
    run_ack(1);
    vectors++;
    if (isr !== 8'h04 || vector_out !== 8'h42) begin
      miscompares++;
      $display("FAIL basic_result: isr=%h vec=%h required isr=04 vec=42", isr, vector_out);
    end
  endtask

  task automatic test_nested();
    // Continues with ISR = 8'h04 left by test_basic
    irr = 8'h08; imr = 8'h00;
    cyc();
    vectors++;
    if (int_out !== 1'b0) begin
      miscompares++;
      $display("FAIL nested_lower: int=%b required 0", int_out);
    end
    irr = 8'h04;
    cyc();
    vectors++;
    if (int_out !== 1'b0) begin
      miscompares++;
      $display("FAIL nested_equal: int=%b required 0", int_out);
    end
    irr = 8'h01;
    cyc();
    vectors++;
    if (int_out !== 1'b1) begin
      miscompares++;
      $display("FAIL nested_higher: int=%b required 1", int_out);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    irr = 8'($urandom_range(1, 255)); imr = 8'hFF; base = 5'($urandom);
    cyc();
    vectors++;
    if (int_out !== 1'b0) begin
      miscompares++;
      $display("FAIL spur_int: int=%b required 0", int_out);
    end
    run_ack(2);
  endtask

  task automatic test_rotate();
    do_reset();
    irr = 8'h10; imr = 8'h00; base = 5'h1F;
    cyc();
    run_ack(0);
    apply_eoi(1'b0, 3'd0, 1'b1);
    vectors++;
    if (isr !== 8'h00 || lp_m != 4) begin
      miscompares++;
      $display("FAIL rotate_eoi: isr=%h model_lp=%0d required isr=00 lp=4", isr, lp_m);
    end
    irr = 8'h11;
    cyc();
    run_ack(0);
    vectors++;
    if (vector_out[2:0] !== 3'd0) begin
      miscompares++;
      $display("FAIL rotate_winner: level=%0d required 0", vector_out[2:0]);
    end
  endtask

  task automatic test_eoi_collision();
    do_reset();
    irr = 8'h02; imr = 8'h00; base = 5'h03;
    cyc();
    inta = 1'b1; cyc(); inta = 1'b0;
    // ACK1 cycle: specific EOI aimed at the bit being set
    eoi_valid = 1'b1; eoi_spec = 1'b1; eoi_lvl = 3'd1;
    cyc();
    eoi_valid = 1'b0; irr = 8'h00;
    isr_m = 8'h02;
    vectors++;
    if (isr !== 8'h02) begin
      miscompares++;
      $display("FAIL eoi_collision: isr=%h required 02", isr);
    end
    inta = 1'b1; cyc(); inta = 1'b0;
    vectors++;
    if (vector_valid !== 1'b1 || vector_out !== 8'h19) begin
      miscompares++;
      $display("FAIL collision_vec: valid=%b vec=%h required valid=1 vec=19", vector_valid, vector_out);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    irr = 8'h40; imr = 8'h00; base = 5'h0A;
    cyc();
    inta = 1'b1; cyc(); inta = 1'b0;
    cyc();
    cyc();
    reset = 1'b1; inta = 1'b1;
    cyc();
    reset = 1'b0; inta = 1'b0; irr = 8'h00;
    isr_m = '0; lp_m = 7;
    vectors++;
    if (freeze !== 1'b0 || isr !== 8'h00 || int_out !== 1'b0 || vector_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: freeze=%b isr=%h int=%b vv=%b required all 0",
               freeze, isr, int_out, vector_valid);
    end
    cyc();
    vectors++;
    if (vector_valid !== 1'b0 || freeze !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_after: vv=%b freeze=%b required 0 0", vector_valid, freeze);
    end
  endtask

`ifdef PIC_AUTO_EOI_EN
  task automatic test_auto_eoi();
    do_reset();
    auto_eoi = 1'b1;
    irr = 8'h02; imr = 8'h00; base = 5'h11;
    cyc();
    run_ack(1);
    vectors++;
    if (isr !== 8'h00) begin
      miscompares++;
      $display("FAIL auto_eoi: isr=%h required 00", isr);
    end
    auto_eoi = 1'b0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 60; n++) begin
      irr  = 8'($urandom);
      imr  = 8'($urandom) & 8'($urandom);
      base = 5'($urandom);
      cyc();
      vectors++;
      if (int_out !== exp_int()) begin
        miscompares++;
        $display("FAIL rand_int[%0d]: int=%b required %b (irr=%h imr=%h isr=%h)",
                 n, int_out, exp_int(), irr, imr, isr_m);
      end
      if ($urandom_range(0, 2) != 0) run_ack($urandom_range(0, 3));
      else apply_eoi(1'($urandom), 3'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) apply_eoi(1'b0, 3'd0, 1'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1; irr = '0; imr = '0; base = '0; inta = 1'b0;
    eoi_valid = 1'b0; eoi_spec = 1'b0; eoi_lvl = '0; rot = 1'b0;
`ifdef PIC_AUTO_EOI_EN
    auto_eoi = 1'b0;
`endif
    isr_m = '0; lp_m = 7;
    test_reset();
    test_basic();
    test_nested();
    test_spurious();
    test_rotate();
    test_eoi_collision();
    test_reset_mid();
`ifdef PIC_AUTO_EOI_EN
    test_auto_eoi();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
